// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: feeds an external combinational 4-bit adder (fa4) one
// nibble per cycle, LSB first, and rebuilds the full-width sum.
// The carry ripples between nibbles through carry_q.
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds an op_sub port, which selects
// A - B instead of A + B.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                 op_sub,
`endif
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W     = 4 * NIBBLES;
  // A single nibble still needs a 1-bit index so the vectors stay legal.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  // State and datapath registers; reset wins over any handshake in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, nibble sequencing and handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    fa_a       = 4'h0;
    fa_b       = 4'h0;
    fa_cin     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = op_a;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
          // Subtract as A + ~B + 1; op_cin is ignored in that mode.
          b_d      = op_sub ? ~op_b : op_b;
          carry_d  = op_sub ? 1'b1 : op_cin;
`else
          b_d      = op_b;
          carry_d  = op_cin;
`endif
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        fa_a    = a_q[4*idx_q +: 4];
        fa_b    = b_q[4*idx_q +: 4];
        fa_cin  = carry_q;
        result_d[4*idx_q +: 4] = fa_sum;
        carry_d = fa_cout;
        if (idx_q == LAST_IDX) begin
          // Final nibble: fa_sum[3] is the sign bit of the finished result.
          cout_d     = fa_cout;
          overflow_d = (a_q[W-1] == b_q[W-1]) && (fa_sum[3] != a_q[W-1]);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES = 4) with a behavioural
// fa4 wired to the fa_* ports. Define NIBBLE_SERIAL_ADDER_SUB_EN to also
// exercise subtraction.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         op_sub;
`endif
  logic [3:0]   fa_a;
  logic [3:0]   fa_b;
  logic         fa_cin;
  logic [3:0]   fa_sum;
  logic         fa_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic [N-1:0] fcin_seen;

  always #5 clk = ~clk;

  // External fa4: purely combinational 4-bit full adder.
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {4'h0, fa_cin};

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub    (op_sub),
`endif
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run one operation to DONE, checking handshake timing, and leave it in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub   = sub;
`endif
    in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    step();  // accept edge
    in_valid = 1'b0;
    chk({tag, ".in_ready_run"}, in_ready, 0);
    chk({tag, ".fa_a_nib0"}, fa_a, a[3:0]);
    for (int i = 0; i < N; i++) begin
      fcin_seen[i] = fa_cin;
      if (i < N - 1) chk({tag, ".out_valid_early"}, out_valid, 0);
      step();
    end
    chk({tag, ".out_valid_latency"}, out_valid, 1);
    chk({tag, ".fa_zero_done"}, {23'h0, fa_a, fa_b, fa_cin}, 0);
    $display("op %s a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d ovf=%0d",
             tag, a, b, cin, sub, result, cout, overflow);
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".in_ready_after"}, in_ready, 1);
    chk({tag, ".out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub    = 1'b0;
`endif
    #1;
    step();
    step();
    chk("reset.in_ready", in_ready, 1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.result", result, 0);
    chk("reset.cout", cout, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.fa", {23'h0, fa_a, fa_b, fa_cin}, 0);
    rst = 1'b0;
    step();

    // Basic add
    run_op("basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    chk("basic.result", result, 32'h2233);
    chk("basic.cout", cout, 0);
    chk("basic.overflow", overflow, 0);
    drain("basic");

    // Full carry ripple
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("ripple.result", result, 32'h0000);
    chk("ripple.cout", cout, 1);
    chk("ripple.overflow", overflow, 0);
    chk("ripple.fa_cin_seq", fcin_seen, 4'b1110);
    drain("ripple");

    // Signed overflow
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b1, 1'b0);
    chk("ovf.result", result, 32'h8001);
    chk("ovf.cout", cout, 0);
    chk("ovf.overflow", overflow, 1);
    drain("ovf");

    // Backpressure with ignored operands
    run_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      op_a     = 16'hAAAA;
      op_b     = 16'h5555;
      chk("bp.result_hold", result, 32'h3333);
      chk("bp.out_valid_hold", out_valid, 1);
      chk("bp.in_ready_low", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    chk("bp.result_final", result, 32'h3333);
    drain("bp");
    chk("bp.result_idle", result, 32'h3333);
    step();
    chk("bp.no_restart", in_ready, 1);

    // Reset during the 2nd RUN cycle
    op_a = 16'h0F0F; op_b = 16'h0101; op_cin = 1'b0;
    in_valid = 1'b1;
    step();  // accept; RUN cycle 1
    in_valid = 1'b0;
    step();  // RUN cycle 2
    chk("rstmid.in_run", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid.in_ready", in_ready, 1);
    chk("rstmid.out_valid", out_valid, 0);
    chk("rstmid.fa", {23'h0, fa_a, fa_b, fa_cin}, 0);
    for (int i = 0; i < N + 2; i++) begin
      chk("rstmid.no_out", out_valid, 0);
      step();
    end
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("after_rst.result", result, 32'h0002);
    chk("after_rst.cout", cout, 0);
    drain("after_rst");

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("sub1.result", result, 32'hFFFE);
    chk("sub1.cout", cout, 0);
    chk("sub1.overflow", overflow, 0);
    drain("sub1");
    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("sub2.result", result, 32'h7FFF);
    chk("sub2.cout", cout, 1);
    chk("sub2.overflow", overflow, 1);
    drain("sub2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
